// File: rtl/mc_datapath_regs_pkg.sv
// Shared constants, select encodings and helpers for the multicycle datapath.
// Imported by mc_regfile and mc_datapath_regs.
package mc_datapath_regs_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    typedef enum logic [2:0] {
        ALUSRCB_B        = 3'b000,
        ALUSRCB_FOUR     = 3'b001,
        ALUSRCB_IMM      = 3'b010,
        ALUSRCB_IMM_SH2  = 3'b011,
        ALUSRCB_IMM_ADDI = 3'b100
    } alusrcb_e;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// r0 reads as zero and ignores writes; rst (active low, synchronous) clears all.
// Ports: clk, rst, we_i/waddr_i/wdata_i (write), raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o.
module mc_regfile
    import mc_datapath_regs_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]     rdata_a_o,
    output logic [DATA_W-1:0]     rdata_b_o
);

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];

    always_comb begin
        rf_d = rf_q;
        if (we_i && (waddr_i != '0)) begin
            rf_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    // Reads see the stored value, so a same-cycle write is not bypassed.
    assign rdata_a_o = (raddr_a_i == '0) ? '0 : rf_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : rf_q[raddr_b_i];

endmodule

// File: rtl/mc_datapath_regs.sv
// Multicycle datapath state: PC, IR, MDR, A, B, ALUOut and the register file.
// Inputs: control-unit selects/enables, alu_result_i, mem_rdata_i.
// Outputs: mem_addr_o/mem_wdata_o/mem_be_o, alu_a_o/alu_b_o, op_o/funct_o, pc_o.
module mc_datapath_regs #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcen_i,
    input  logic              iord_i,
    input  logic              irwrite_i,
    input  logic              memwrite_i,
    input  logic              regwrite_i,
    input  logic              regdst_i,
    input  logic              memtoreg_i,
    input  logic              alusrca_i,
    input  logic [2:0]        alusrcb_i,
    input  logic [1:0]        pcsource_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [DATA_W-1:0] pc_o
);

    import mc_datapath_regs_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;

    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] imm_ext;
    logic [1:0]  lane;
    logic [7:0]  load_byte;

    assign imm_ext  = sext16(ir_q[15:0]);
    assign lane     = aluout_q[1:0];
    assign rf_waddr = regdst_i ? ir_q[15:11] : ir_q[20:16];

    always_comb begin
        load_byte = '0;
        unique case (lane)
            2'd0: load_byte = mdr_q[7:0];
            2'd1: load_byte = mdr_q[15:8];
            2'd2: load_byte = mdr_q[23:16];
            2'd3: load_byte = mdr_q[31:24];
            default: load_byte = '0;
        endcase
    end

    assign rf_wdata = memtoreg_i ? sext8(load_byte) : aluout_q;

    mc_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (regwrite_i),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (ir_q[25:21]),
        .raddr_b_i (ir_q[20:16]),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    always_comb begin
        pc_d     = pc_q;
        ir_d     = irwrite_i ? mem_rdata_i : ir_q;
        mdr_d    = mem_rdata_i;
        a_d      = rf_rdata_a;
        b_d      = rf_rdata_b;
        aluout_d = alu_result_i;
        if (pcen_i) begin
            unique case (pcsource_i)
                PCSRC_ALU:    pc_d = alu_result_i;
                PCSRC_ALUOUT: pc_d = aluout_q;
                // PC already holds PC+4 here, so its top nibble is the region.
                PCSRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                PCSRC_HOLD:   pc_d = pc_q;
                default:      pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    always_comb begin
        alu_b_o = '0;
        case (alusrcb_i)
            ALUSRCB_B:        alu_b_o = b_q;
            ALUSRCB_FOUR:     alu_b_o = 32'd4;
            ALUSRCB_IMM:      alu_b_o = imm_ext;
            ALUSRCB_IMM_SH2:  alu_b_o = imm_ext << 2;
            ALUSRCB_IMM_ADDI: alu_b_o = imm_ext;
            default:          alu_b_o = '0;
        endcase
    end

    assign alu_a_o     = alusrca_i ? a_q : pc_q;
    assign mem_addr_o  = iord_i ? aluout_q : pc_q;
    assign mem_wdata_o = {4{b_q[7:0]}};
    assign mem_be_o    = memwrite_i ? (4'b0001 << lane) : 4'b0000;
    assign op_o        = ir_q[31:26];
    assign funct_o     = ir_q[5:0];
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Scoreboard bench for mc_datapath_regs: expectations queued with stimulus,
// popped and compared once the outputs settle.
module tb_mc_datapath_regs;

    typedef enum int {
        OBS_PC, OBS_ADDR, OBS_BE, OBS_WDATA,
        OBS_ALUA, OBS_ALUB, OBS_OP, OBS_FUNCT
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] val;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcen, iord, irwrite, memwrite, regwrite;
    logic        regdst, memtoreg, alusrca;
    logic [2:0]  alusrcb;
    logic [1:0]  pcsource;
    logic [31:0] alu_result, mem_rdata;
    logic [31:0] mem_addr, mem_wdata, alu_a, alu_b, pc;
    logic [3:0]  mem_be;
    logic [5:0]  op, funct;

    sb_item_t sb_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_datapath_regs #(
        .DATA_W   (32),
        .PC_RESET (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pcen_i       (pcen),
        .iord_i       (iord),
        .irwrite_i    (irwrite),
        .memwrite_i   (memwrite),
        .regwrite_i   (regwrite),
        .regdst_i     (regdst),
        .memtoreg_i   (memtoreg),
        .alusrca_i    (alusrca),
        .alusrcb_i    (alusrcb),
        .pcsource_i   (pcsource),
        .alu_result_i (alu_result),
        .mem_rdata_i  (mem_rdata),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .op_o         (op),
        .funct_o      (funct),
        .pc_o         (pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs_val(input obs_e s);
        case (s)
            OBS_PC:    return pc;
            OBS_ADDR:  return mem_addr;
            OBS_BE:    return {28'h0, mem_be};
            OBS_WDATA: return mem_wdata;
            OBS_ALUA:  return alu_a;
            OBS_ALUB:  return alu_b;
            OBS_OP:    return {26'h0, op};
            OBS_FUNCT: return {26'h0, funct};
            default:   return 32'hx;
        endcase
    endfunction

    task automatic sb_push(input string tag, input obs_e s,
                           input logic [31:0] v);
        sb_item_t it;
        it.tag = tag;
        it.sel = s;
        it.val = v;
        sb_q.push_back(it);
    endtask

    task automatic sb_drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_eq(it.tag, obs_val(it.sel), it.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sb_drain();
    endtask

    task automatic settle();
        #1;
        sb_drain();
    endtask

    task automatic idle();
        pcen = 0; iord = 0; irwrite = 0; memwrite = 0; regwrite = 0;
        regdst = 0; memtoreg = 0; alusrca = 0;
        alusrcb = 3'b000; pcsource = 2'b00;
        alu_result = '0; mem_rdata = '0;
    endtask

    task automatic read_reg(input logic [4:0] n, input logic [31:0] v);
        idle();
        mem_rdata = {6'h00, n, 21'h0};
        irwrite = 1;
        step();
        idle();
        step();
        alusrca = 1;
        sb_push($sformatf("rf%0d", n), OBS_ALUA, v);
        settle();
        idle();
    endtask

    task automatic write_reg(input logic [4:0] n, input logic [31:0] v);
        idle();
        mem_rdata = {6'h00, 5'd0, n, 16'h0};
        irwrite = 1;
        alu_result = v;
        step();
        idle();
        regwrite = 1;
        step();
        idle();
    endtask

    task automatic do_load(input logic [4:0] rt, input logic [31:0] word,
                           input logic [1:0] ln);
        idle();
        mem_rdata = {6'h20, 5'd0, rt, 16'h0};
        irwrite = 1;
        alu_result = {30'h0, ln};
        step();
        irwrite = 0;
        mem_rdata = word;
        step();
        idle();
        regwrite = 1;
        memtoreg = 1;
        step();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  sb_sel;
        logic [31:0] sb_exp;

        idle();
        rst = 0;
        #1;
        step();
        step();
        rst = 1;
        sb_push("rst_pc", OBS_PC, 32'h0);
        sb_push("rst_addr", OBS_ADDR, 32'h0);
        sb_push("rst_be", OBS_BE, 32'h0);
        sb_push("rst_op", OBS_OP, 32'h0);
        settle();
        for (int i = 0; i < 32; i++) read_reg(5'(i), 32'h0);

        // addi r8,r0,5
        idle();
        mem_rdata = 32'h2008_0005;
        irwrite = 1; pcen = 1; alusrcb = 3'b001;
        pcsource = 2'b00; alu_result = 32'd4;
        sb_push("fetch_alub", OBS_ALUB, 32'd4);
        sb_push("fetch_alua", OBS_ALUA, 32'd0);
        settle();
        sb_push("fetch_pc", OBS_PC, 32'd4);
        sb_push("fetch_op", OBS_OP, 32'h08);
        sb_push("fetch_funct", OBS_FUNCT, 32'h05);
        step();
        idle();
        step();
        alusrca = 1; alusrcb = 3'b100; alu_result = 32'd5;
        sb_push("addi_alub", OBS_ALUB, 32'd5);
        sb_push("addi_alua", OBS_ALUA, 32'd0);
        settle();
        step();
        idle();
        regwrite = 1;
        step();
        read_reg(5'd8, 32'd5);

        // rd-destination write
        idle();
        mem_rdata = {6'h00, 5'd0, 5'd14, 5'd13, 11'h0};
        irwrite = 1;
        alu_result = 32'h77;
        step();
        idle();
        regwrite = 1; regdst = 1;
        step();
        read_reg(5'd13, 32'h77);
        read_reg(5'd14, 32'h0);

        // store
        write_reg(5'd10, 32'hAB);
        alusrcb = 3'b000;
        sb_push("nobypass_b", OBS_ALUB, 32'h0);
        settle();
        alu_result = 32'h102;
        step();
        memwrite = 1; iord = 1;
        sb_push("st_addr", OBS_ADDR, 32'h102);
        sb_push("st_be", OBS_BE, 32'h4);
        sb_push("st_wdata", OBS_WDATA, 32'hABAB_ABAB);
        sb_push("st_b", OBS_ALUB, 32'hAB);
        settle();
        memwrite = 0;
        sb_push("st_be_off", OBS_BE, 32'h0);
        settle();
        for (int l = 0; l < 4; l++) begin
            idle();
            alu_result = 32'h100 | 32'(l);
            step();
            memwrite = 1; iord = 1;
            sb_push($sformatf("st_be_lane%0d", l), OBS_BE, 32'(1 << l));
            settle();
        end

        // loads
        do_load(5'd9, 32'h80FF_1234, 2'd3);
        read_reg(5'd9, 32'hFFFF_FF80);
        do_load(5'd9, 32'h80FF_1234, 2'd0);
        read_reg(5'd9, 32'h0000_0034);
        do_load(5'd9, 32'h80FF_1234, 2'd2);
        read_reg(5'd9, 32'hFFFF_FFFF);
        do_load(5'd9, 32'h80FF_1234, 2'd1);
        read_reg(5'd9, 32'h0000_0012);

        // jump / branch / hold
        idle();
        mem_rdata = {6'h02, 26'h10};
        irwrite = 1; pcen = 1; alu_result = 32'h1000_0004;
        sb_push("j_fetch_pc", OBS_PC, 32'h1000_0004);
        step();
        idle();
        pcen = 1; pcsource = 2'b10; alu_result = 32'h300;
        sb_push("j_pc", OBS_PC, 32'h1000_0040);
        step();
        pcen = 0; pcsource = 2'b01;
        sb_push("br_nopcen", OBS_PC, 32'h1000_0040);
        step();
        pcen = 1; pcsource = 2'b11;
        sb_push("pc_hold", OBS_PC, 32'h1000_0040);
        step();
        pcsource = 2'b01; alu_result = 32'h400;
        sb_push("pc_aluout", OBS_PC, 32'h300);
        step();
        idle();
        sb_push("addr_pc", OBS_ADDR, 32'h300);
        sb_push("alua_pc", OBS_ALUA, 32'h300);
        settle();

        // ALU B immediate forms
        idle();
        mem_rdata = 32'h2008_FFF0;
        irwrite = 1;
        step();
        idle();
        for (int s = 2; s < 8; s++) begin
            sb_sel = 3'(s);
            case (s)
                2, 4:    sb_exp = 32'hFFFF_FFF0;
                3:       sb_exp = 32'hFFFF_FFC0;
                default: sb_exp = 32'h0;
            endcase
            alusrcb = sb_sel;
            sb_push($sformatf("alub_sel%0d", s), OBS_ALUB, sb_exp);
            settle();
            #1;
        end

        // r0 and reset during writeback
        write_reg(5'd0, 32'hDEAD_BEEF);
        read_reg(5'd0, 32'h0);
        write_reg(5'd12, 32'h55);
        read_reg(5'd12, 32'h55);
        idle();
        mem_rdata = {6'h00, 5'd0, 5'd11, 16'h0};
        irwrite = 1; pcen = 1; alu_result = 32'h1234;
        step();
        idle();
        regwrite = 1;
        rst = 0;
        sb_push("wrrst_pc", OBS_PC, 32'h0);
        sb_push("wrrst_op", OBS_OP, 32'h0);
        step();
        rst = 1;
        idle();
        read_reg(5'd11, 32'h0);
        read_reg(5'd12, 32'h0);
        read_reg(5'd8, 32'h0);
        read_reg(5'd13, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
